// File: rtl/gnt_ack_pkg.sv
// Shared types and helpers for the grant/ack responder.
package gnt_ack_pkg;

    localparam int unsigned MAX_LAT_DEF = 4;
    localparam int unsigned DEPTH_DEF   = 4;
    localparam int unsigned ID_W_DEF    = 2;
    localparam int unsigned LAT_W_DEF   = $clog2(MAX_LAT_DEF + 1);
    // rem only ever holds L-1, so MAX_LAT-1 is its largest value
    localparam int unsigned REM_W_DEF   = (MAX_LAT_DEF > 1) ? $clog2(MAX_LAT_DEF) : 1;

    // One outstanding grant; late mirrors (rem == 0) so the head flag is ready to register
    typedef struct packed {
        logic [ID_W_DEF-1:0]  id;
        logic [REM_W_DEF-1:0] rem;
        logic                 late;
    } resp_entry_t;

    // Effective latency: 0 becomes 1, anything above max_lat becomes max_lat
    function automatic logic [LAT_W_DEF-1:0] clamp_lat(input logic [LAT_W_DEF-1:0] lat,
                                                       input int unsigned        max_lat);
        logic [LAT_W_DEF-1:0] eff;
        if (lat == '0) begin
            eff = LAT_W_DEF'(1);
        end else if (32'(lat) > max_lat) begin
            eff = LAT_W_DEF'(max_lat);
        end else begin
            eff = lat;
        end
        return eff;
    endfunction

endpackage

// File: rtl/gnt_ack_responder_queue.sv
// Circular FIFO of outstanding grants with per-entry saturating countdown.
module resp_queue
    import gnt_ack_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  resp_entry_t                  data_i,
    input  logic                         pop_i,
    output resp_entry_t                  head_c,
    output logic                         full_c,
    output logic                         empty_c,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    resp_entry_t      r_mem [DEPTH];
    resp_entry_t      w_aged [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full_c  = (r_count == CNT_W'(DEPTH));
    assign empty_c = (r_count == '0);
    assign head_c  = r_mem[r_rd_ptr];
    assign count_o = r_count;

    // A push into a full queue only lands when the head leaves on the same edge
    assign w_push = push_i && (!full_c || pop_i);
    assign w_pop  = pop_i && !empty_c;

    // Age every valid entry by one edge, saturating at zero
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_aged[i] = r_mem[i];
            if (r_valid[i]) begin
                if (r_mem[i].rem != '0) begin
                    w_aged[i].rem = r_mem[i].rem - REM_W_DEF'(1);
                end
                w_aged[i].late = (r_mem[i].rem <= REM_W_DEF'(1));
            end
        end
    end

    // Entry storage: new grant written at the tail, everything else ages
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_push && (r_wr_ptr == PTR_W'(i))) begin
                r_mem[i] <= data_i;
            end else begin
                r_mem[i] <= w_aged[i];
            end
        end
    end

    // Valid bits, pointers and occupancy; push wins when it reuses the popped slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (r_wr_ptr == PTR_W'(i))) begin
                    r_valid[i] <= 1'b1;
                end else if (w_pop && (r_rd_ptr == PTR_W'(i))) begin
                    r_valid[i] <= 1'b0;
                end
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/gnt_ack_responder.sv
// Grant/ack responder: one ack per accepted grant, FIFO order, 1..MAX_LAT cycles later.
// MAX_LAT and ID_W must not exceed the package defaults, which size the shared entry type.
module gnt_ack_responder
    import gnt_ack_pkg::*;
#(
    parameter int unsigned MAX_LAT = MAX_LAT_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned ID_W    = ID_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          gnt_i,
    input  logic [ID_W-1:0]               gnt_id_i,
    input  logic [$clog2(MAX_LAT+1)-1:0]  lat_i,
    output logic                          ack_o,
    output logic [ID_W-1:0]               ack_id_o,
    output logic                          ack_late_o,
    output logic [$clog2(DEPTH+1)-1:0]    outstanding_o,
    output logic                          overflow_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [LAT_W_DEF-1:0] w_lat_eff;
    logic                 w_lat_one;
    resp_entry_t          w_push_entry;
    resp_entry_t          w_head;
    logic                 w_full;
    logic                 w_empty;
    logic [CNT_W-1:0]     w_count;
    logic                 w_issue;
    logic                 w_bypass;
    logic                 w_accept;
    logic                 w_drop;

    assign w_lat_eff = clamp_lat(LAT_W_DEF'(lat_i), MAX_LAT);
    assign w_lat_one = (w_lat_eff == LAT_W_DEF'(1));

    // Head is acked once it is one edge from due (rem 1) or already past it (rem 0)
    assign w_issue  = !w_empty && (w_head.rem <= REM_W_DEF'(1));
    // L=1 can only be met on time by skipping the queue, which needs an idle queue
    assign w_bypass = gnt_i && w_lat_one && w_empty;
    assign w_accept = gnt_i && !w_bypass && (!w_full || w_issue);
    assign w_drop   = gnt_i && !w_bypass && w_full && !w_issue;

    // New entry: rem counts edges left after this one, so L=1 enters already late
    always_comb begin
        w_push_entry      = '0;
        w_push_entry.id   = ID_W_DEF'(gnt_id_i);
        w_push_entry.rem  = REM_W_DEF'(w_lat_eff - LAT_W_DEF'(1));
        w_push_entry.late = w_lat_one;
    end

    resp_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_accept),
        .data_i  (w_push_entry),
        .pop_i   (w_issue),
        .head_c  (w_head),
        .full_c  (w_full),
        .empty_c (w_empty),
        .count_o (w_count)
    );

    assign outstanding_o = w_count;

    // Ack pulse, tag/late hold between acks, sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_o      <= 1'b0;
            ack_id_o   <= '0;
            ack_late_o <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            ack_o <= w_issue || w_bypass;
            if (w_issue) begin
                ack_id_o   <= ID_W'(w_head.id);
                ack_late_o <= w_head.late;
            end else if (w_bypass) begin
                ack_id_o   <= gnt_id_i;
                ack_late_o <= 1'b0;
            end
            if (w_drop) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gnt_ack_responder.sv
// Directed bench for gnt_ack_responder with an ack scoreboard.
module tb_gnt_ack_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       gnt_i;
    logic [1:0] gnt_id_i;
    logic [2:0] lat_i;
    logic       ack_o;
    logic [1:0] ack_id_o;
    logic       ack_late_o;
    logic [1:0] outstanding_o;
    logic       overflow_o;

    typedef struct {
        int id;
        int late;
        int edge_s;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   edge_n = 0;
    int   total  = 0;
    int   bad    = 0;

    gnt_ack_responder #(
        .MAX_LAT (4),
        .DEPTH   (2),
        .ID_W    (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .gnt_i         (gnt_i),
        .gnt_id_i      (gnt_id_i),
        .lat_i         (lat_i),
        .ack_o         (ack_o),
        .ack_id_o      (ack_id_o),
        .ack_late_o    (ack_late_o),
        .outstanding_o (outstanding_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Values seen at the negedge after edge k are the ones sampled at edge k+1
    always @(negedge clk) begin
        if (ack_o === 1'b1) begin
            chk("ack_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("ack_edge", 32'(edge_n + 1), 32'(mon_e.edge_s));
                chk("ack_id",   32'(ack_id_o),   32'(mon_e.id));
                chk("ack_late", 32'(ack_late_o), 32'(mon_e.late));
            end
        end
    end

    // Drive a grant so it is sampled at edge n; ack_edge < 0 means it must be dropped
    task automatic grant_at(input int n, input int id, input int lat,
                            input int ack_edge, input int late);
        exp_t e;
        while (edge_n < n - 1) @(negedge clk);
        if (ack_edge > 0) begin
            e.id = id; e.late = late; e.edge_s = ack_edge;
            sb.push_back(e);
        end
        gnt_i    = 1'b1;
        gnt_id_i = 2'(id);
        lat_i    = 3'(lat);
        @(negedge clk);
        gnt_i = 1'b0;
    endtask

    task automatic wait_edge(input int n);
        while (edge_n < n) @(negedge clk);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired at edge %0d", edge_n);
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        gnt_i    = 1'b0;
        gnt_id_i = '0;
        lat_i    = '0;
        @(negedge clk);
        wait_edge(2);
        chk("rst_ack",      32'(ack_o),         32'd0);
        chk("rst_ack_id",   32'(ack_id_o),      32'd0);
        chk("rst_ack_late", 32'(ack_late_o),    32'd0);
        chk("rst_out",      32'(outstanding_o), 32'd0);
        chk("rst_ovf",      32'(overflow_o),    32'd0);
        rst = 1'b0;

        // basic latency 3
        grant_at(5, 2, 3, 8, 0);
        chk("basic_out5", 32'(outstanding_o), 32'd1);
        wait_edge(6);
        chk("basic_out6", 32'(outstanding_o), 32'd1);
        wait_edge(7);
        chk("basic_out7", 32'(outstanding_o), 32'd0);

        // minimum latency via bypass, lat 1 and lat 0
        grant_at(10, 1, 1, 11, 0);
        chk("byp1_out", 32'(outstanding_o), 32'd0);
        grant_at(13, 1, 0, 14, 0);
        chk("byp0_out", 32'(outstanding_o), 32'd0);

        // latency above MAX_LAT clamps to 4
        grant_at(16, 3, 7, 20, 0);
        chk("clamp_out", 32'(outstanding_o), 32'd1);

        // back-to-back grants, lat 2
        grant_at(20, 0, 2, 22, 0);
        grant_at(21, 1, 2, 23, 0);
        chk("stream_out", 32'(outstanding_o), 32'd1);
        grant_at(22, 2, 2, 24, 0);
        grant_at(23, 3, 2, 25, 0);
        wait_edge(26);
        chk("stream_out_end", 32'(outstanding_o), 32'd0);
        chk("stream_ovf",     32'(overflow_o),    32'd0);

        // a short grant stuck behind a long one comes out late
        grant_at(30, 0, 4, 34, 0);
        grant_at(31, 1, 1, 35, 1);
        chk("coll_out", 32'(outstanding_o), 32'd2);
        wait_edge(37);
        chk("hold_id",   32'(ack_id_o),      32'd1);
        chk("hold_late", 32'(ack_late_o),    32'd1);
        chk("coll_end",  32'(outstanding_o), 32'd0);

        // third grant into a two-deep queue is dropped
        grant_at(40, 0, 4, 44, 0);
        grant_at(41, 1, 4, 45, 0);
        chk("ovf_before", 32'(overflow_o), 32'd0);
        grant_at(42, 2, 4, -1, 0);
        chk("ovf_set",   32'(overflow_o),    32'd1);
        chk("ovf_out",   32'(outstanding_o), 32'd2);
        wait_edge(46);
        chk("ovf_sticky", 32'(overflow_o),    32'd1);
        chk("ovf_end",    32'(outstanding_o), 32'd0);

        // reset with grants pending discards them
        grant_at(50, 1, 4, -1, 0);
        grant_at(51, 2, 4, -1, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ack",  32'(ack_o),         32'd0);
        chk("mid_rst_id",   32'(ack_id_o),      32'd0);
        chk("mid_rst_late", 32'(ack_late_o),    32'd0);
        chk("mid_rst_out",  32'(outstanding_o), 32'd0);
        chk("mid_rst_ovf",  32'(overflow_o),    32'd0);
        grant_at(54, 3, 2, 56, 0);

        wait_edge(64);
        chk("sb_drained", 32'(sb.size()),     32'd0);
        chk("final_out",  32'(outstanding_o), 32'd0);
        chk("final_ovf",  32'(overflow_o),    32'd0);
        chk("final_ack",  32'(ack_o),         32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
